pgm_linebuf_dual: RTL

- Parametrised, double-buffered sprite line buffer: the next generation of the fixed 448x10-bit two-bank buffer in the PGM video path.
- The sprite fetcher writes decoded pixels into the write bank. The mixer reads the other bank during active display, and each read clears the entry it returns.
- Adds over the previous generation:
  - parametrised line width and pixel/palette/priority widths;
  - valid/ready write handshake;
  - x clipping;
  - transparency handling;
  - hardware clear sweep after a bank swap;
  - optional per-pixel priority arbitration.

---
 rtl/pgm_video_pkg.sv | 29 ++
 rtl/pgm_linebuf_bank.sv | 51 +++++
 rtl/pgm_linebuf_dual.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pgm_video_pkg.sv
// rtl/pgm_video_pkg.sv - shared types and constants for the PGM video line buffers
//
// Purpose: common entry layout, line-buffer FSM states and default sizes used
// by pgm_linebuf_dual and its bank sub-module.
// Ports: none (package).
package pgm_video_pkg;

    localparam int LB_DEFAULT_W    = 448;
    localparam int PIX_TRANSPARENT = 0;

    localparam int LB_PIX_W = 5;
    localparam int LB_PAL_W = 5;
    localparam int LB_PRI_W = 2;

    // Default-width entry layout of the video path; the buffer itself packs
    // fields in the same order (pri above pal above pix) at its own widths.
    typedef struct packed {
        logic [LB_PRI_W-1:0] pri;
        logic [LB_PAL_W-1:0] pal;
        logic [LB_PIX_W-1:0] pix;
    } lb_entry_t;

    typedef enum logic [1:0] {
        SWEEP_ALL = 2'd0,
        SWEEP     = 2'd1,
        ACCEPT    = 2'd2
    } lb_state_e;

endpackage

// File: rtl/pgm_linebuf_bank.sv
// rtl/pgm_linebuf_bank.sv - one line-buffer bank, one write port and one registered read port
//
// Purpose: DEPTH x DW storage. A write and a read in the same cycle to the same
// address return the old word (read-before-write).
// Ports:
//   clk, reset       clock, asynchronous active-low reset (read register only)
//   we/waddr/wdata   write port
//   re/raddr         read request; rdata updates on the next edge, holds otherwise
//   rdata            registered read data
module pgm_linebuf_bank #(
    parameter int DEPTH = 448,
    parameter int AW    = 9,
    parameter int DW    = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/pgm_linebuf_dual.sv
// rtl/pgm_linebuf_dual.sv - double-buffered sprite line buffer with clipping, sweep and arbitration
//
// Purpose: the sprite fetcher writes into bank wr_bank while the mixer reads
// (and clears) the other bank. line_start swaps banks and sweeps the new write
// bank to zero. Optional macro PGM_LINEBUF_LB_PRI_EN adds per-pixel priority.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   line_start                 bank swap pulse
//   wr_valid/wr_ready          write handshake; wr_x/wr_pix/wr_pal/wr_pri payload
//   rd_en/rd_x                 mixer read request
//   rd_valid/rd_pix/pal/pri    read response one cycle later
//   wr_bank                    current write bank
//   clip_cnt                   saturating clipped/lost write count for this line
module pgm_linebuf_dual
    import pgm_video_pkg::*;
#(
    parameter int LINE_W = LB_DEFAULT_W,
    parameter int PIX_W  = 5,
    parameter int PAL_W  = 5,
    parameter int PRI_W  = 2,
    parameter int XW     = 11,
    parameter int AW     = $clog2(LINE_W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             line_start,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [XW-1:0]    wr_x,
    input  logic [PIX_W-1:0] wr_pix,
    input  logic [PAL_W-1:0] wr_pal,
    input  logic [PRI_W-1:0] wr_pri,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_x,
    output logic             rd_valid,
    output logic [PIX_W-1:0] rd_pix,
    output logic [PAL_W-1:0] rd_pal,
    output logic [PRI_W-1:0] rd_pri,
    output logic             wr_bank,
    output logic [15:0]      clip_cnt
);

`ifdef PGM_LINEBUF_LB_PRI_EN
    localparam int EW = PIX_W + PAL_W + PRI_W;
`else
    localparam int EW = PIX_W + PAL_W;
`endif
    localparam logic [PIX_W-1:0] PIX_CLR = PIX_W'(PIX_TRANSPARENT);

    lb_state_e        state_q, state_d;
    logic [AW-1:0]    sweep_addr_q, sweep_addr_d;
    logic             wr_bank_q, wr_bank_d;
    logic [15:0]      clip_cnt_q, clip_cnt_d;

    // Arbitration stage: write issued last cycle, waiting for the stored word.
    logic             p1_valid_q, p1_valid_d;
    logic [AW-1:0]    p1_x_q, p1_x_d;
    logic [EW-1:0]    p1_word_q, p1_word_d;
    logic             p1_bank_q, p1_bank_d;

    // Word committed on the previous edge; the bank read issued in that same
    // cycle returned the pre-commit value, so this overrides it on address match.
    logic             byp_valid_q, byp_valid_d;
    logic [AW-1:0]    byp_x_q, byp_x_d;
    logic [EW-1:0]    byp_word_q, byp_word_d;

    logic             rd_valid_q, rd_valid_d;
    logic             rd_oob_q, rd_oob_d;
    logic             rd_bank_q, rd_bank_d;
    logic [PIX_W-1:0] rd_pix_q, rd_pix_d;
    logic [PAL_W-1:0] rd_pal_q, rd_pal_d;
    logic [PRI_W-1:0] rd_pri_q, rd_pri_d;

    logic             bank_we    [2];
    logic [AW-1:0]    bank_waddr [2];
    logic [EW-1:0]    bank_wdata [2];
    logic             bank_re    [2];
    logic [AW-1:0]    bank_raddr [2];
    logic [EW-1:0]    bank_rdata [2];

    logic             wr_in_range, wr_accept, wr_issue, rd_in_range, commit, lose;
    logic [AW-1:0]    wr_addr;
    logic [EW-1:0]    wr_word, stored_word, rd_word;
    logic [1:0]       clip_inc;
    logic [16:0]      clip_sum;

    // FSM: sweeps count LINE_W cycles; line_start overrides from any state.
    always_comb begin
        state_d      = state_q;
        sweep_addr_d = sweep_addr_q;
        wr_bank_d    = wr_bank_q;
        case (state_q)
            SWEEP_ALL, SWEEP: begin
                if (sweep_addr_q == AW'(LINE_W - 1)) begin
                    state_d      = ACCEPT;
                    sweep_addr_d = '0;
                end else begin
                    sweep_addr_d = sweep_addr_q + AW'(1);
                end
            end
            ACCEPT:  state_d = ACCEPT;
            default: state_d = SWEEP_ALL;
        endcase
        if (line_start) begin
            state_d      = SWEEP;
            sweep_addr_d = '0;
            wr_bank_d    = ~wr_bank_q;
        end
        wr_ready = (state_q == ACCEPT) && !line_start;
    end

    always_comb begin
        wr_in_range = !wr_x[XW-1] && (int'(wr_x) < LINE_W);
        wr_addr     = wr_x[AW-1:0];
        wr_accept   = wr_valid && wr_ready;
        wr_issue    = wr_accept && wr_in_range && (wr_pix != PIX_CLR);
`ifdef PGM_LINEBUF_LB_PRI_EN
        wr_word     = {wr_pri, wr_pal, wr_pix};
`else
        wr_word     = {wr_pal, wr_pix};
`endif

        stored_word = (byp_valid_q && (byp_x_q == p1_x_q)) ? byp_word_q : bank_rdata[p1_bank_q];
`ifdef PGM_LINEBUF_LB_PRI_EN
        commit = p1_valid_q && ((stored_word[PIX_W-1:0] == PIX_CLR) ||
                                (p1_word_q[EW-1 -: PRI_W] > stored_word[EW-1 -: PRI_W]));
`else
        commit = p1_valid_q && (stored_word[PIX_W-1:0] == PIX_CLR);
`endif
        lose = p1_valid_q && !commit;

        // An out-of-range accept and a losing decision can land in the same cycle.
        clip_inc = 2'(wr_accept && !wr_in_range) + 2'(lose);
        clip_sum = {1'b0, clip_cnt_q} + 17'(clip_inc);
        if (line_start) begin
            clip_cnt_d = '0;
        end else if (clip_sum[16]) begin
            clip_cnt_d = '1;
        end else begin
            clip_cnt_d = clip_sum[15:0];
        end

        p1_valid_d  = wr_issue;
        p1_x_d      = wr_addr;
        p1_word_d   = wr_word;
        p1_bank_d   = wr_bank_q;
        byp_valid_d = commit;
        byp_x_d     = p1_x_q;
        byp_word_d  = p1_word_q;

        rd_in_range = int'(rd_x) < LINE_W;
        rd_valid_d  = rd_en;
        rd_oob_d    = !rd_in_range;
        rd_bank_d   = ~wr_bank_q;

        // Commits only happen in ACCEPT (the accept cycle before cannot carry
        // line_start), so the write bank never sees a sweep and a commit together.
        // On the read bank the reset-time sweep wins over clear-on-read: both
        // write zero and any skipped entry is still ahead of the sweep.
        for (int b = 0; b < 2; b++) begin
            bank_we[b]    = 1'b0;
            bank_waddr[b] = '0;
            bank_wdata[b] = '0;
            bank_re[b]    = 1'b0;
            bank_raddr[b] = '0;
            if (wr_bank_q == 1'(b)) begin
                bank_re[b]    = wr_issue;
                bank_raddr[b] = wr_addr;
                bank_we[b]    = commit || (state_q != ACCEPT);
                bank_waddr[b] = (state_q == ACCEPT) ? p1_x_q : sweep_addr_q;
                bank_wdata[b] = (state_q == ACCEPT) ? p1_word_q : '0;
            end else begin
                bank_re[b]    = rd_en && rd_in_range;
                bank_raddr[b] = rd_x;
                bank_we[b]    = (state_q == SWEEP_ALL) || (rd_en && rd_in_range);
                bank_waddr[b] = (state_q == SWEEP_ALL) ? sweep_addr_q : rd_x;
            end
        end

        rd_word = bank_rdata[rd_bank_q];
        rd_pix  = rd_pix_q;
        rd_pal  = rd_pal_q;
        rd_pri  = rd_pri_q;
        if (rd_valid_q) begin
            if (rd_oob_q) begin
                rd_pix = '0;
                rd_pal = '0;
                rd_pri = '0;
            end else begin
                rd_pix = rd_word[PIX_W-1:0];
                rd_pal = rd_word[PIX_W +: PAL_W];
`ifdef PGM_LINEBUF_LB_PRI_EN
                rd_pri = rd_word[EW-1 -: PRI_W];
`else
                rd_pri = '0;
`endif
            end
        end
        rd_pix_d = rd_pix;
        rd_pal_d = rd_pal;
        rd_pri_d = rd_pri;
    end

`ifndef PGM_LINEBUF_LB_PRI_EN
    logic unused_pri;
    assign unused_pri = ^wr_pri;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= SWEEP_ALL;
            sweep_addr_q <= '0;
            wr_bank_q    <= 1'b0;
            clip_cnt_q   <= '0;
            p1_valid_q   <= 1'b0;
            p1_x_q       <= '0;
            p1_word_q    <= '0;
            p1_bank_q    <= 1'b0;
            byp_valid_q  <= 1'b0;
            byp_x_q      <= '0;
            byp_word_q   <= '0;
            rd_valid_q   <= 1'b0;
            rd_oob_q     <= 1'b0;
            rd_bank_q    <= 1'b0;
            rd_pix_q     <= '0;
            rd_pal_q     <= '0;
            rd_pri_q     <= '0;
        end else begin
            state_q      <= state_d;
            sweep_addr_q <= sweep_addr_d;
            wr_bank_q    <= wr_bank_d;
            clip_cnt_q   <= clip_cnt_d;
            p1_valid_q   <= p1_valid_d;
            p1_x_q       <= p1_x_d;
            p1_word_q    <= p1_word_d;
            p1_bank_q    <= p1_bank_d;
            byp_valid_q  <= byp_valid_d;
            byp_x_q      <= byp_x_d;
            byp_word_q   <= byp_word_d;
            rd_valid_q   <= rd_valid_d;
            rd_oob_q     <= rd_oob_d;
            rd_bank_q    <= rd_bank_d;
            rd_pix_q     <= rd_pix_d;
            rd_pal_q     <= rd_pal_d;
            rd_pri_q     <= rd_pri_d;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        pgm_linebuf_bank #(
            .DEPTH (LINE_W),
            .AW    (AW),
            .DW    (EW)
        ) u_bank (
            .clk   (clk),
            .reset (reset),
            .we    (bank_we[g]),
            .waddr (bank_waddr[g]),
            .wdata (bank_wdata[g]),
            .re    (bank_re[g]),
            .raddr (bank_raddr[g]),
            .rdata (bank_rdata[g])
        );
    end

    assign rd_valid = rd_valid_q;
    assign wr_bank  = wr_bank_q;
    assign clip_cnt = clip_cnt_q;

endmodule
